// File: rtl/proc_ctrl.sv
// Control FSM for the 4-register processor: fetches IR from DIN and sequences each instruction over T0..T3.
// Latency: mv/mvi/illegal finish in the cycle after fetch; add/sub finish 3 cycles after fetch.
// Backpressure: none. Run is sampled only in T0, and a started instruction always runs to completion unless Reset is asserted.
module proc_ctrl #(
  parameter int CMD_LENGTH = 9,
  parameter int REG_NUM    = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic [CMD_LENGTH-1:0] DIN,
  output logic [REG_NUM-1:0]    Rout,
  output logic                  Gout,
  output logic                  DINout,
  output logic [REG_NUM-1:0]    Rin,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  AddSub,
  output logic                  IRin,
  output logic [CMD_LENGTH-1:0] IR,
  output logic                  Done,
  output logic [1:0]            Tstep
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  step_t                 step;
  logic [CMD_LENGTH-1:0] ir_q;
  logic [2:0]            opcode;
  logic [2:0]            rx;
  logic [2:0]            ry;
  logic                  legal;
  logic                  arith;

  // A register field selects a real register only if it is below REG_NUM.
  function automatic logic reg_ok(input logic [2:0] r);
    return int'(r) < REG_NUM;
  endfunction

  // One-hot select: R0 sits in the MSB, the highest register in bit 0.
  function automatic logic [REG_NUM-1:0] sel(input logic [2:0] r);
    logic [REG_NUM-1:0] s;
    s = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (r == 3'(i)) s[REG_NUM-1-i] = 1'b1;
    end
    return s;
  endfunction

  assign opcode = ir_q[CMD_LENGTH-1 -: 3];
  assign rx     = ir_q[CMD_LENGTH-4 -: 3];
  assign ry     = ir_q[CMD_LENGTH-7 -: 3];
  // Opcodes 1xx and out-of-range register fields execute as a NOP.
  assign legal  = ~opcode[2] & reg_ok(rx) & reg_ok(ry);
  // add/sub are the only instructions that use T2 and T3.
  assign arith  = legal & opcode[1];

  assign IR     = ir_q;
  assign Tstep  = step;

  // Step sequencer and instruction register; Reset aborts any instruction in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      step <= T0;
      ir_q <= '0;
    end else begin
      case (step)
        T0: begin
          if (Run) begin
            ir_q <= DIN;
            step <= T1;
          end
        end
        T1: step <= arith ? T2 : T0;
        T2: step <= arith ? T3 : T0;
        T3: step <= T0;
      endcase
    end
  end

  // Control decode from step and IR; DINout is the bus default so exactly one source is always selected.
  always_comb begin
    Rout   = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    IRin   = 1'b0;
    Done   = 1'b0;
    case (step)
      T0: begin
        DINout = 1'b1;
        IRin   = Run;
      end
      T1: begin
        if (!legal) begin
          DINout = 1'b1;
          Done   = 1'b1;
        end else begin
          case (opcode[1:0])
            2'b00: begin
              Rout = sel(ry);
              Rin  = sel(rx);
              Done = 1'b1;
            end
            2'b01: begin
              DINout = 1'b1;
              Rin    = sel(rx);
              Done   = 1'b1;
            end
            default: begin
              Rout = sel(rx);
              Ain  = 1'b1;
            end
          endcase
        end
      end
      T2: begin
        if (arith) begin
          Rout   = sel(ry);
          Gin    = 1'b1;
          AddSub = opcode[0];
        end else begin
          DINout = 1'b1;
        end
      end
      T3: begin
        if (arith) begin
          Gout   = 1'b1;
          Rin    = sel(rx);
          AddSub = opcode[0];
          Done   = 1'b1;
        end else begin
          DINout = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: directed step-by-step control checks plus random instruction streams.
// A reference register-file model predicts each instruction's result; a monitor emulates the datapath from the DUT's controls.
// Each Done pops the scoreboard and compares IR, latency, step and register contents.
module tb_proc_ctrl;
  localparam int CL = 9;
  localparam int RN = 4;

  logic          Clock;
  logic          Reset;
  logic          Run;
  logic [CL-1:0] DIN;
  logic [RN-1:0] Rout;
  logic          Gout;
  logic          DINout;
  logic [RN-1:0] Rin;
  logic          Ain;
  logic          Gin;
  logic          AddSub;
  logic          IRin;
  logic [CL-1:0] IR;
  logic          Done;
  logic [1:0]    Tstep;

  proc_ctrl #(.CMD_LENGTH(CL), .REG_NUM(RN)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .IRin(IRin),
    .IR(IR), .Done(Done), .Tstep(Tstep)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct packed {
    logic [8:0]  ir;
    logic [1:0]  lat;
    logic [35:0] regs;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] ref_r[4];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [13:0] ctl;
  assign ctl = {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input logic [3:0] rout, input logic gout, input logic dinout,
                                     input logic [3:0] rin, input logic ain, input logic gin,
                                     input logic addsub, input logic done);
    return {rout, gout, dinout, rin, ain, gin, addsub, done};
  endfunction

  localparam logic [13:0] T0V = 14'b0000_0_1_0000_0_0_0_0;

  function automatic bit is_legal(input logic [8:0] ins);
    return (ins[8:6] < 3'd4) && (ins[5:3] < 3'd4) && (ins[2:0] < 3'd4);
  endfunction

  // Reference model: apply the instruction's architectural effect and queue the expected outcome.
  task automatic push_expect(input logic [8:0] ins, input logic [8:0] imm);
    logic [2:0] op;
    logic [1:0] x;
    logic [1:0] y;
    exp_t       e;
    op = ins[8:6];
    x  = ins[4:3];
    y  = ins[1:0];
    e.ir  = ins;
    e.lat = 2'd1;
    if (is_legal(ins)) begin
      case (op)
        3'd0: ref_r[x] = ref_r[y];
        3'd1: ref_r[x] = imm;
        3'd2: begin ref_r[x] = ref_r[x] + ref_r[y]; e.lat = 2'd3; end
        default: begin ref_r[x] = ref_r[x] - ref_r[y]; e.lat = 2'd3; end
      endcase
    end
    e.regs = {ref_r[0], ref_r[1], ref_r[2], ref_r[3]};
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Drive one cycle and compare the control outputs at the falling edge.
  task automatic step_chk(input string name, input logic run, input logic [8:0] din,
                          input logic [13:0] exp_ctl, input logic [1:0] exp_t);
    Run = run;
    DIN = din;
    @(negedge Clock);
    check(name, 36'({ctl, IRin}), 36'({exp_ctl, (exp_t == 2'd0) & run}));
    check({name, "_tstep"}, 36'(Tstep), 36'(exp_t));
    cyc();
  endtask

  // Issue a whole instruction with random filler on the don't-care inputs.
  task automatic issue(input logic [8:0] ins, input logic [8:0] imm, input int gap);
    repeat (gap) begin
      Run = 1'b0;
      DIN = 9'($urandom);
      cyc();
    end
    push_expect(ins, imm);
    Run = 1'b1;
    DIN = ins;
    cyc();
    Run = 1'($urandom_range(0, 1));
    DIN = (ins[8:6] == 3'd1) ? imm : 9'($urandom);
    cyc();
    if (is_legal(ins) && ins[7]) begin
      repeat (2) begin
        Run = 1'($urandom_range(0, 1));
        DIN = 9'($urandom);
        cyc();
      end
    end
  endtask

  // Monitor: emulate the register/ALU datapath from the DUT's controls and score each Done.
  initial begin
    logic [8:0] emr[4];
    logic [8:0] ea;
    logic [8:0] eg;
    logic [8:0] bus;
    logic [8:0] na;
    logic [8:0] ng;
    int         lat;
    bit         inflight;
    exp_t       e;
    for (int i = 0; i < 4; i++) emr[i] = '0;
    ea = '0;
    eg = '0;
    lat = 0;
    inflight = 0;
    forever begin
      @(negedge Clock);
      if (Reset) continue;
      check("onehot_bus", 36'($countones({Rout, Gout, DINout})), 36'd1);
      if (inflight) lat++;
      if (Tstep == 2'd0) check("t0_ctl", 36'({ctl, IRin}), 36'({T0V, Run}));
      bus = '0;
      for (int i = 0; i < 4; i++) if (Rout[3-i]) bus = emr[i];
      if (Gout) bus = eg;
      if (DINout) bus = DIN;
      na = Ain ? bus : ea;
      ng = Gin ? (AddSub ? ea - bus : ea + bus) : eg;
      for (int i = 0; i < 4; i++) if (Rin[3-i]) emr[i] = bus;
      ea = na;
      eg = ng;
      if (Done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got Done=1 expected no instruction pending at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("done_ir", 36'(IR), 36'(e.ir));
          check("done_latency", 36'(lat), 36'(e.lat));
          check("done_tstep", 36'(Tstep), 36'(e.lat));
          check("done_regs", {emr[0], emr[1], emr[2], emr[3]}, e.regs);
        end
        inflight = 0;
      end
      if (Tstep == 2'd0 && Run) begin
        lat = 0;
        inflight = 1;
      end
    end
  end

  // Stimulus: reset/idle, directed instruction sequences, reset mid-add, then a random stream.
  initial begin
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    for (int i = 0; i < 4; i++) ref_r[i] = '0;
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      Run = 1'b0;
      DIN = 9'($urandom);
      @(negedge Clock);
      check("idle_ctl", 36'({ctl, IRin}), 36'({T0V, 1'b0}));
      check("idle_tstep", 36'(Tstep), 36'd0);
      check("idle_ir", 36'(IR), 36'd0);
      cyc();
    end

    push_expect(9'b001_000_000, 9'd5);
    step_chk("mvi_fetch", 1'b1, 9'b001_000_000, T0V, 2'd0);
    step_chk("mvi_t1", 1'b0, 9'd5, mk(4'b0000, 0, 1, 4'b1000, 0, 0, 0, 1), 2'd1);

    push_expect(9'b000_011_000, 9'd0);
    step_chk("mv_fetch", 1'b1, 9'b000_011_000, T0V, 2'd0);
    step_chk("mv_t1", 1'b1, 9'h1ff, mk(4'b1000, 0, 0, 4'b0001, 0, 0, 0, 1), 2'd1);

    issue(9'b001_001_000, 9'd7, 0);
    issue(9'b001_010_000, 9'd3, 1);

    push_expect(9'b010_001_010, 9'd0);
    step_chk("add_fetch", 1'b1, 9'b010_001_010, T0V, 2'd0);
    step_chk("add_t1", 1'b1, 9'h0aa, mk(4'b0100, 0, 0, 4'b0000, 1, 0, 0, 0), 2'd1);
    step_chk("add_t2", 1'b1, 9'h155, mk(4'b0010, 0, 0, 4'b0000, 0, 1, 0, 0), 2'd2);
    step_chk("add_t3", 1'b0, 9'h033, mk(4'b0000, 1, 0, 4'b0100, 0, 0, 0, 1), 2'd3);

    push_expect(9'b011_000_000, 9'd0);
    step_chk("sub_fetch", 1'b1, 9'b011_000_000, T0V, 2'd0);
    step_chk("sub_t1", 1'b0, 9'h1f0, mk(4'b1000, 0, 0, 4'b0000, 1, 0, 0, 0), 2'd1);
    step_chk("sub_t2", 1'b0, 9'h00f, mk(4'b1000, 0, 0, 4'b0000, 0, 1, 1, 0), 2'd2);
    step_chk("sub_t3", 1'b0, 9'h1a5, mk(4'b0000, 1, 0, 4'b1000, 0, 0, 1, 1), 2'd3);

    push_expect(9'b100_000_001, 9'd0);
    step_chk("ill_op_fetch", 1'b1, 9'b100_000_001, T0V, 2'd0);
    step_chk("ill_op_t1", 1'b0, 9'h0ff, mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 1), 2'd1);
    push_expect(9'b000_101_000, 9'd0);
    step_chk("ill_reg_fetch", 1'b1, 9'b000_101_000, T0V, 2'd0);
    step_chk("ill_reg_t1", 1'b0, 9'h0ff, mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 1), 2'd1);
    step_chk("ill_after", 1'b0, 9'h000, T0V, 2'd0);

    step_chk("rst_fetch", 1'b1, 9'b010_001_010, T0V, 2'd0);
    step_chk("rst_t1", 1'b0, 9'h000, mk(4'b0100, 0, 0, 4'b0000, 1, 0, 0, 0), 2'd1);
    Reset = 1'b1;
    step_chk("rst_t2", 1'b0, 9'h000, mk(4'b0010, 0, 0, 4'b0000, 0, 1, 0, 0), 2'd2);
    Reset = 1'b0;
    Run   = 1'b0;
    @(negedge Clock);
    check("rst_after_ctl", 36'({ctl, IRin}), 36'({T0V, 1'b0}));
    check("rst_after_tstep", 36'(Tstep), 36'd0);
    check("rst_after_ir", 36'(IR), 36'd0);
    cyc();
    issue(9'b010_001_010, 9'd0, 0);

    for (int n = 0; n < 250; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) op[2] = 1'b0;
      x = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      y = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      issue({op, x, y}, 9'($urandom), int'($urandom_range(0, 2)));
    end

    Run = 1'b0;
    repeat (6) cyc();
    check("scoreboard_drained", 36'(exp_q.size()), 36'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
